// File: rtl/accel_router.sv
// CPU accelerator-port router: one TX (CPU->accel) and one RX (accel->CPU) FIFO per channel.
// CPU-side status and read data are combinational from accel_id; ids >= ACCEL_COUNT never stall.

module accel_router_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem[rd_ptr_q];

  // Pop is judged on the pre-edge count, so a push into an empty FIFO is never popped the same cycle.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end
endmodule

module accel_router #(
  parameter int ACCEL_COUNT = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [3:0]                        accel_id,
  output logic                              accel_can_read,
  output logic                              accel_can_write,
  input  logic                              accel_read_enable,
  output logic [DATA_WIDTH-1:0]             accel_read_data,
  input  logic                              accel_write_enable,
  input  logic [DATA_WIDTH-1:0]             accel_write_data,
  output logic [ACCEL_COUNT-1:0]            down_valid,
  input  logic [ACCEL_COUNT-1:0]            down_ready,
  output logic [ACCEL_COUNT*DATA_WIDTH-1:0] down_data,
  input  logic [ACCEL_COUNT-1:0]            up_valid,
  output logic [ACCEL_COUNT-1:0]            up_ready,
  input  logic [ACCEL_COUNT*DATA_WIDTH-1:0] up_data
);
  logic [ACCEL_COUNT-1:0]            sel;
  logic [ACCEL_COUNT-1:0]            tx_full, tx_empty, rx_full, rx_empty;
  logic [ACCEL_COUNT*DATA_WIDTH-1:0] rx_head;

  for (genvar g = 0; g < ACCEL_COUNT; g++) begin : g_chan
    assign sel[g]        = (accel_id == 4'(g));
    assign down_valid[g] = !tx_empty[g];
    assign up_ready[g]   = !rx_full[g];

    accel_router_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_tx (
      .clk       (clk),
      .rst_n     (rst),
      .push      (accel_write_enable && sel[g]),
      .push_data (accel_write_data),
      .pop       (down_ready[g]),
      .head      (down_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .full      (tx_full[g]),
      .empty     (tx_empty[g])
    );

    accel_router_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_rx (
      .clk       (clk),
      .rst_n     (rst),
      .push      (up_valid[g]),
      .push_data (up_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .pop       (accel_read_enable && sel[g]),
      .head      (rx_head[g*DATA_WIDTH +: DATA_WIDTH]),
      .full      (rx_full[g]),
      .empty     (rx_empty[g])
    );
  end

  // Unmapped ids report ready in both directions and read as zero so the CPU cannot hang.
  always_comb begin
    accel_can_read  = 1'b1;
    accel_can_write = 1'b1;
    accel_read_data = '0;
    for (int i = 0; i < ACCEL_COUNT; i++) begin
      if (sel[i]) begin
        accel_can_read  = !rx_empty[i];
        accel_can_write = !tx_full[i];
        accel_read_data = rx_head[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_accel_router.sv
// Directed bench for accel_router: per-channel queue model checked every cycle,
// plus hand-computed expectations from the test plan.

module tb_accel_router;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int DEP = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [3:0]      accel_id = '0;
  logic            accel_can_read, accel_can_write;
  logic            accel_read_enable = 1'b0;
  logic [DW-1:0]   accel_read_data;
  logic            accel_write_enable = 1'b0;
  logic [DW-1:0]   accel_write_data = '0;
  logic [NCH-1:0]  down_valid;
  logic [NCH-1:0]  down_ready = '0;
  logic [NCH*DW-1:0] down_data;
  logic [NCH-1:0]  up_valid = '0;
  logic [NCH-1:0]  up_ready;
  logic [NCH*DW-1:0] up_data = '0;

  int total  = 0;
  int passed = 0;

  logic [DW-1:0] txq [NCH][$];
  logic [DW-1:0] rxq [NCH][$];

  accel_router #(.ACCEL_COUNT(NCH), .DATA_WIDTH(DW), .FIFO_DEPTH(DEP)) dut (
    .clk                (clk),
    .rst                (rst),
    .accel_id           (accel_id),
    .accel_can_read     (accel_can_read),
    .accel_can_write    (accel_can_write),
    .accel_read_enable  (accel_read_enable),
    .accel_read_data    (accel_read_data),
    .accel_write_enable (accel_write_enable),
    .accel_write_data   (accel_write_data),
    .down_valid         (down_valid),
    .down_ready         (down_ready),
    .down_data          (down_data),
    .up_valid           (up_valid),
    .up_ready           (up_ready),
    .up_data            (up_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Model: transfers decided from queue occupancy before the edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        bit tpush, tpop, rpush, rpop;
        tpop  = (txq[i].size() > 0) && down_ready[i];
        tpush = accel_write_enable && (int'(accel_id) == i) && (txq[i].size() < DEP);
        rpop  = accel_read_enable && (int'(accel_id) == i) && (rxq[i].size() > 0);
        rpush = up_valid[i] && (rxq[i].size() < DEP);
        if (tpop)  void'(txq[i].pop_front());
        if (tpush) txq[i].push_back(accel_write_data);
        if (rpop)  void'(rxq[i].pop_front());
        if (rpush) rxq[i].push_back(up_data[i*DW +: DW]);
      end
    end
  end

  always @(negedge rst) begin
    for (int i = 0; i < NCH; i++) begin
      txq[i].delete();
      rxq[i].delete();
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    int id;
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("down_valid[%0d]", i), 32'(down_valid[i]), 32'(txq[i].size() != 0));
      if (txq[i].size() != 0)
        chk($sformatf("down_data[%0d]", i), 32'(down_data[i*DW +: DW]), 32'(txq[i][0]));
      chk($sformatf("up_ready[%0d]", i), 32'(up_ready[i]), 32'(rxq[i].size() < DEP));
    end
    id = int'(accel_id);
    if (id < NCH) begin
      chk("can_write", 32'(accel_can_write), 32'(txq[id].size() < DEP));
      chk("can_read", 32'(accel_can_read), 32'(rxq[id].size() != 0));
      if (rxq[id].size() != 0) chk("read_data", 32'(accel_read_data), 32'(rxq[id][0]));
    end else begin
      chk("can_write_unmapped", 32'(accel_can_write), 32'd1);
      chk("can_read_unmapped", 32'(accel_can_read), 32'd1);
      chk("read_data_unmapped", 32'(accel_read_data), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] dd(input int ch);
    return down_data[ch*DW +: DW];
  endfunction

  initial begin
    // Reset state
    step(); step();
    accel_id = 4'd0;
    #1;
    chk("rst down_valid", 32'(down_valid), 32'h0);
    chk("rst up_ready", 32'(up_ready), 32'hF);
    chk("rst can_read", 32'(accel_can_read), 32'd0);
    chk("rst can_write", 32'(accel_can_write), 32'd1);
    accel_id = 4'd5;
    #1;
    chk("rst read_data unmapped", 32'(accel_read_data), 32'h0);
    rst = 1'b1;
    step();

    // TX channel 1: two writes, then drain
    accel_id = 4'd1; accel_write_enable = 1'b1; accel_write_data = 16'h1234;
    step();
    accel_write_data = 16'hABCD;
    #1;
    chk("t1 down_valid", 32'(down_valid[1]), 32'd1);
    chk("t1 down_data", 32'(dd(1)), 32'h1234);
    step();
    accel_write_enable = 1'b0;
    down_ready[1] = 1'b1;
    #1;
    chk("t1 head0", 32'(dd(1)), 32'h1234);
    step();
    #1;
    chk("t1 head1", 32'(dd(1)), 32'hABCD);
    chk("t1 valid1", 32'(down_valid[1]), 32'd1);
    step();
    down_ready[1] = 1'b0;
    #1;
    chk("t1 drained", 32'(down_valid[1]), 32'd0);

    // TX channel 2: fill, full flag, one handshake frees a slot
    accel_id = 4'd2; accel_write_enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      accel_write_data = 16'h0020 + 16'(k);
      step();
    end
    accel_write_enable = 1'b0;
    #1;
    chk("t2 full can_write", 32'(accel_can_write), 32'd0);
    accel_id = 4'd0;
    #1;
    chk("t2 other id can_write", 32'(accel_can_write), 32'd1);
    down_ready[2] = 1'b1;
    step();
    down_ready[2] = 1'b0;
    accel_id = 4'd2;
    #1;
    chk("t2 can_write after pop", 32'(accel_can_write), 32'd1);
    chk("t2 head after pop", 32'(dd(2)), 32'h0021);
    down_ready[2] = 1'b1;
    step(); step(); step();
    down_ready[2] = 1'b0;

    // RX channel 3: fill with 1..4, 5 held back, then CPU drains 1..5
    accel_id = 4'd0; up_valid[3] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      up_data[3*DW +: DW] = 16'(k);
      step();
    end
    up_data[3*DW +: DW] = 16'h0005;
    #1;
    chk("t3 up_ready full", 32'(up_ready[3]), 32'd0);
    step();
    chk("t3 up_ready still full", 32'(up_ready[3]), 32'd0);
    accel_id = 4'd3;
    for (int k = 1; k <= 5; k++) begin
      accel_read_enable = 1'b0;
      #1;
      chk("t3 can_read", 32'(accel_can_read), 32'd1);
      chk("t3 read_data", 32'(accel_read_data), 32'(k));
      accel_read_enable = 1'b1;
      step();
      if (k == 2) up_valid[3] = 1'b0;
    end
    accel_read_enable = 1'b0;
    #1;
    chk("t3 empty", 32'(accel_can_read), 32'd0);

    // RX channel 0: simultaneous push and pop on a two-entry FIFO
    accel_id = 4'd1; up_valid[0] = 1'b1;
    up_data[0 +: DW] = 16'h0010; step();
    up_data[0 +: DW] = 16'h0011; step();
    up_data[0 +: DW] = 16'h00FF;
    accel_id = 4'd0; accel_read_enable = 1'b1;
    #1;
    chk("t4 head before", 32'(accel_read_data), 32'h0010);
    step();
    up_valid[0] = 1'b0;
    #1;
    chk("t4 head after", 32'(accel_read_data), 32'h0011);
    step();
    #1;
    chk("t4 ordering", 32'(accel_read_data), 32'h00FF);
    step();
    accel_read_enable = 1'b0;
    #1;
    chk("t4 empty", 32'(accel_can_read), 32'd0);

    // Unmapped id
    accel_id = 4'd5;
    #1;
    chk("t5 can_read", 32'(accel_can_read), 32'd1);
    chk("t5 can_write", 32'(accel_can_write), 32'd1);
    chk("t5 read_data", 32'(accel_read_data), 32'h0);
    accel_write_enable = 1'b1; accel_write_data = 16'hDEAD; accel_read_enable = 1'b1;
    step();
    accel_write_enable = 1'b0; accel_read_enable = 1'b0;
    #1;
    chk("t5 no down_valid", 32'(down_valid), 32'h0);

    // Asynchronous reset with data in TX1 and RX1
    accel_id = 4'd1; accel_write_enable = 1'b1; up_valid[1] = 1'b1;
    accel_write_data = 16'h0031; up_data[1*DW +: DW] = 16'h0041; step();
    accel_write_data = 16'h0032; up_data[1*DW +: DW] = 16'h0042; step();
    up_valid[1] = 1'b0;
    accel_write_data = 16'h0033; step();
    accel_write_enable = 1'b0;
    #1;
    chk("t6 pre down_valid", 32'(down_valid[1]), 32'd1);
    chk("t6 pre can_read", 32'(accel_can_read), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("t6 rst down_valid", 32'(down_valid[1]), 32'd0);
    chk("t6 rst can_read", 32'(accel_can_read), 32'd0);
    chk("t6 rst can_write", 32'(accel_can_write), 32'd1);
    step();
    rst = 1'b1;
    accel_write_enable = 1'b1; accel_write_data = 16'h0051; step();
    accel_write_data = 16'h0052; step();
    accel_write_enable = 1'b0; down_ready[1] = 1'b1;
    #1;
    chk("t6 fresh head0", 32'(dd(1)), 32'h0051);
    step();
    #1;
    chk("t6 fresh head1", 32'(dd(1)), 32'h0052);
    step();
    down_ready[1] = 1'b0;
    #1;
    chk("t6 fresh drained", 32'(down_valid[1]), 32'd0);
    step(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
